// File: rtl/fp_add_sched.sv
// fp_add_sched: one multi-cycle IEEE754 single-precision adder shared by two
// requesters. It accepts one operand pair at a time and runs it through
// ALIGN/ADD/NORM/EXC. The sum comes back on a valid/ready channel tagged with
// the requester id.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0_valid/a/b/ready     requester 0 operand channel
//   req1_valid/a/b/ready     requester 1 operand channel
//   res_valid/ready          result channel handshake
//   res_data, res_id         sum and owning requester
//   busy                     high whenever the FSM is not in IDLE
//
// Parameters
//   ARB_MODE  0 = round-robin, 1 = fixed priority (req0 wins)
//   RR_INIT   requester holding round-robin priority after reset
//
// state | meaning
// IDLE  | waiting for an operand pair, readies may assert
// ALIGN | unpack, order by magnitude, shift smaller mantissa
// ADD   | 25-bit add or subtract of aligned mantissas
// NORM  | renormalise mantissa and exponent
// EXC   | overflow/underflow handling, pack result
// DONE  | result presented until the consumer takes it
module fp_add_sched #(
  parameter logic ARB_MODE = 1'b0,
  parameter logic RR_INIT  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_id,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, EXC, DONE} state_t;

  state_t      state;
  logic        prio;
  logic        grant;
  logic        id_q;
  logic [31:0] op_a, op_b;

  logic        sign_l, eff_sub;
  logic [7:0]  exp_l;
  logic [23:0] mant_l, mant_s;
  logic [24:0] sum;
  logic [22:0] mant_n;
  logic [8:0]  exp_n;

  logic        a_big;
  logic [31:0] lop, sop;
  logic [7:0]  dexp;
  logic [23:0] ms_raw;
  logic [23:0] ml_c, ms_c;
  logic [24:0] sum_c;
  logic [4:0]  lz;
  logic [22:0] mant_n_c;
  logic [8:0]  exp_n_c;
  logic [8:0]  exp_r;
  logic [31:0] packed_c;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic found;
    lzc24 = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else lzc24 = lzc24 + 5'd1;
      end
    end
  endfunction

  // Fixed mode ignores prio; a lone valid always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ARB_MODE ? 1'b0 : prio;
    else grant = !req0_valid;
  end

  assign req0_ready = !rst && (state == IDLE) && !grant && req0_valid;
  assign req1_ready = !rst && (state == IDLE) &&  grant && req1_valid;
  assign busy       = (state != IDLE);

  // Operands with a zero exponent are flushed to exactly zero.
  always_comb begin
    a_big  = (op_a[30:0] >= op_b[30:0]);
    lop    = a_big ? op_a : op_b;
    sop    = a_big ? op_b : op_a;
    dexp   = lop[30:23] - sop[30:23];
    ml_c   = (lop[30:23] != 8'd0) ? {1'b1, lop[22:0]} : 24'd0;
    ms_raw = (sop[30:23] != 8'd0) ? {1'b1, sop[22:0]} : 24'd0;
    ms_c   = (dexp >= 8'd25) ? 24'd0 : (ms_raw >> dexp);
  end

  always_comb begin
    sum_c = eff_sub ? ({1'b0, mant_l} - {1'b0, mant_s})
                    : ({1'b0, mant_l} + {1'b0, mant_s});
  end

  // The hidden bit is dropped during the shift: after shifting by the
  // leading-zero count it would sit at bit 23, outside the 23-bit field.
  always_comb begin
    exp_r    = {1'b0, exp_l};
    lz       = lzc24(sum[23:0]);
    mant_n_c = 23'd0;
    exp_n_c  = 9'd0;
    if (sum[24]) begin
      mant_n_c = sum[23:1];
      exp_n_c  = exp_r + 9'd1;
    end else begin
      mant_n_c = sum[22:0] << lz;
      if ((sum[23:0] == 24'd0) || (exp_r <= {4'd0, lz})) exp_n_c = 9'd0;
      else exp_n_c = exp_r - {4'd0, lz};
    end
  end

  always_comb begin
    if (exp_n >= 9'd255)     packed_c = {sign_l, 8'hFF, 23'd0};
    else if (exp_n == 9'd0)  packed_c = 32'd0;
    else                     packed_c = {sign_l, exp_n[7:0], mant_n};
  end

  // res_valid rises one cycle into DONE, so results appear five edges after
  // the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_data  <= 32'd0;
      res_id    <= 1'b0;
      prio      <= RR_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            op_a  <= grant ? req1_a : req0_a;
            op_b  <= grant ? req1_b : req0_b;
            id_q  <= grant;
            if (!ARB_MODE) prio <= !grant;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          sign_l  <= lop[31];
          eff_sub <= lop[31] ^ sop[31];
          exp_l   <= lop[30:23];
          mant_l  <= ml_c;
          mant_s  <= ms_c;
          state   <= ADD;
        end
        ADD: begin
          sum   <= sum_c;
          state <= NORM;
        end
        NORM: begin
          mant_n <= mant_n_c;
          exp_n  <= exp_n_c;
          state  <= EXC;
        end
        EXC: begin
          res_data <= packed_c;
          res_id   <= id_q;
          state    <= DONE;
        end
        DONE: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            res_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_sched.sv
module tb_fp_add_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready, res_id, busy;
  logic [31:0] res_data;

  logic        f_req0_valid, f_req1_valid, f_req0_ready, f_req1_ready;
  logic [31:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
  logic        f_res_valid, f_res_ready, f_res_id, f_busy;
  logic [31:0] f_res_data;

  fp_add_sched #(.ARB_MODE(1'b0), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  fp_add_sched #(.ARB_MODE(1'b1), .RR_INIT(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(f_req0_valid), .req0_a(f_req0_a), .req0_b(f_req0_b), .req0_ready(f_req0_ready),
    .req1_valid(f_req1_valid), .req1_a(f_req1_a), .req1_b(f_req1_b), .req1_ready(f_req1_ready),
    .res_valid(f_res_valid), .res_ready(f_res_ready), .res_data(f_res_data),
    .res_id(f_res_id), .busy(f_busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        id;
  } exp_t;

  exp_t exp_q[$];
  exp_t fexp_q[$];
  exp_t m_e, f_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // Scoreboard monitors: a handshake seen at the falling edge completes on
  // the next rising edge.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_result: got %08h, expected none", res_data);
      end else begin
        m_e = exp_q.pop_front();
        chk("res_data", res_data, m_e.data);
        chk("res_id", {31'd0, res_id}, {31'd0, m_e.id});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && f_res_valid && f_res_ready) begin
      if (fexp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL fp_spurious_result: got %08h, expected none", f_res_data);
      end else begin
        f_e = fexp_q.pop_front();
        chk("fp_res_data", f_res_data, f_e.data);
        chk("fp_res_id", {31'd0, f_res_id}, {31'd0, f_e.id});
      end
    end
  end

  task automatic wait_accept(input logic id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? req1_ready : req0_ready) && n < 50);
    if (!(id ? req1_ready : req0_ready)) timeout("accept_wait");
    @(posedge clk);
    #1;
    // Operands change after accept; the DUT must have latched them.
    if (id) begin req1_valid = 1'b0; req1_a = 32'hDEADBEEF; req1_b = 32'hDEADBEEF; end
    else    begin req0_valid = 1'b0; req0_a = 32'hDEADBEEF; req0_b = 32'hDEADBEEF; end
  endtask

  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input bit push);
    if (push) exp_q.push_back({e, id});
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    wait_accept(id);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || fexp_q.size() != 0 || f_busy) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) timeout("drain_wait");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, acc, f1_acc;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0;
    res_ready = 1'b1;
    f_req0_valid = 1'b0; f_req0_a = 32'd0; f_req0_b = 32'd0;
    f_req1_valid = 1'b0; f_req1_a = 32'd0; f_req1_b = 32'd0;
    f_res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_id", {31'd0, res_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1.0 + 1.0 with latency measurement
    send(1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd5);
    wait_idle();

    // cancellation, underflow, overflow, aligned subtract, denormal flush
    send(1'b1, 32'h3F800000, 32'hBF800000, 32'h00000000, 1'b1); wait_idle();
    send(1'b0, 32'h00800001, 32'h80800000, 32'h00000000, 1'b1); wait_idle();
    send(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1); wait_idle();
    send(1'b0, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 1'b1); wait_idle();
    send(1'b1, 32'h40A00000, 32'hBF400000, 32'h40880000, 1'b1); wait_idle();
    send(1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000, 1'b1); wait_idle();

    // Round-robin from a fresh reset: 0,1,0,1
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back({32'h40000000, 1'b0});
    exp_q.push_back({32'h40400000, 1'b1});
    exp_q.push_back({32'h40000000, 1'b0});
    exp_q.push_back({32'h40400000, 1'b1});
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h40000000;
    acc = 0; n = 0;
    while (acc < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (req0_ready || req1_ready) acc++;
    end
    if (acc < 4) timeout("rr_accepts");
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Fixed priority: req0 wins three times while both stay valid
    repeat (3) fexp_q.push_back({32'h40000000, 1'b0});
    f_req0_valid = 1'b1; f_req0_a = 32'h3F800000; f_req0_b = 32'h3F800000;
    f_req1_valid = 1'b1; f_req1_a = 32'h3F800000; f_req1_b = 32'h40000000;
    acc = 0; f1_acc = 0; n = 0;
    while (acc < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (f_req0_ready) acc++;
      if (f_req1_ready) f1_acc++;
    end
    if (acc < 3) timeout("fp_accepts");
    @(posedge clk);
    #1;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    wait_idle();
    chk("fp_req1_accepts", 32'(f1_acc), 32'd0);

    // Back-pressure in DONE
    res_ready = 1'b0;
    send(1'b1, 32'h40400000, 32'h3F000000, 32'h40600000, 1'b1);
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!res_valid) timeout("hold_valid_wait");
    exp_q.push_back({32'h40000000, 1'b0});
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    for (int i = 0; i < 3; i++) begin
      chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_res_data", res_data, 32'h40600000);
      chk("hold_res_id", {31'd0, res_id}, 32'd1);
      chk("hold_req0_ready", {31'd0, req0_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_hs_busy", {31'd0, busy}, 32'd0);
    chk("post_hs_res_valid", {31'd0, res_valid}, 32'd0);
    wait_accept(1'b0);
    wait_idle();

    // Reset during ALIGN aborts the operation
    send(1'b0, 32'h3F800000, 32'h3F800000, 32'd0, 1'b0);
    chk("align_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("abort_no_result_valid", {31'd0, res_valid}, 32'd0);
    send(1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1);
    wait_idle();

    chk("queue_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
